// File: rtl/fetch_next_pc.sv
// Fetch controller driving the PC register input: boot vector, sequential step,
// redirect, and a single-entry registered instruction slot toward decode.
module fetch_next_pc #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] INST_STEP    = 32'd4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] pc_current,
    output logic [31:0] pc_next,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    typedef enum logic [1:0] {
        S_BOOT    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_inst_valid;
    logic [31:0] r_inst_data;
    logic [31:0] r_inst_pc;

    logic        w_slot_free;
    logic        w_redirect;
    logic        w_req_fire;
    logic        w_fill;
    logic [31:0] w_redirect_target;
    logic        w_unused_low_bits;

    assign w_slot_free       = !r_inst_valid || inst_ready;
    assign w_redirect        = redirect_valid && (r_state != S_BOOT);
    assign w_redirect_target = {redirect_pc[31:2], 2'b00};
    assign w_unused_low_bits = ^redirect_pc[1:0];

    // Only REQ may present a request, and only when the slot can take its result.
    assign imem_req_valid = (r_state == S_REQ) && w_slot_free;
    assign imem_req_addr  = (r_state == S_REQ) ? pc_current : 32'h0000_0000;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_fill         = (r_state == S_WAIT) && imem_resp_valid && !w_redirect;

    assign inst_valid = r_inst_valid;
    assign inst_data  = r_inst_data;
    assign inst_pc    = r_inst_pc;

    always_comb begin
        pc_next = pc_current;
        if (r_state == S_BOOT) begin
            pc_next = RESET_VECTOR;
        end else if (w_redirect) begin
            pc_next = w_redirect_target;
        end else if (w_fill) begin
            pc_next = pc_current + INST_STEP;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state      <= S_BOOT;
            r_inst_valid <= 1'b0;
            r_inst_data  <= 32'h0000_0000;
            r_inst_pc    <= 32'h0000_0000;
        end else begin
            if (w_redirect) begin
                r_inst_valid <= 1'b0;
            end else if (w_fill) begin
                r_inst_valid <= 1'b1;
                r_inst_data  <= imem_resp_data;
                r_inst_pc    <= pc_current;
            end else if (r_inst_valid && inst_ready) begin
                r_inst_valid <= 1'b0;
            end

            case (r_state)
                S_BOOT: r_state <= S_REQ;
                S_REQ: begin
                    // An accepted request always yields a response; a redirect must discard it.
                    if (w_req_fire) begin
                        r_state <= w_redirect ? S_DISCARD : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        r_state <= S_REQ;
                    end else if (w_redirect) begin
                        r_state <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (imem_resp_valid) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_next_pc.sv
// Bench for fetch_next_pc: models the PC register and instruction memory,
// scoreboards delivered instructions and checks boot, stall, redirect, wrap, reset.
module tb_fetch_next_pc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        CLK = 1'b0;
    logic        reset;
    logic [31:0] pc_current;
    logic [31:0] pc_next;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          last_cons = 0;
    int          n_resp  = 0;
    logic        auto_resp;
    logic        rate_chk;
    logic [31:0] exp_pc;
    exp_t        sb_q[$];
    exp_t        flushed;

    fetch_next_pc #(
        .RESET_VECTOR(32'h0000_0100),
        .INST_STEP   (32'd4)
    ) dut (
        .CLK            (CLK),
        .reset          (reset),
        .pc_current     (pc_current),
        .pc_next        (pc_next),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    always #5 CLK = ~CLK;

    // External PC register: loads pc_next on every edge.
    always @(posedge CLK) pc_current <= pc_next;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; in auto mode, answer last cycle's accepted request with 0xA0+n.
    task automatic step();
        logic hs;
        exp_t e;
        hs = imem_req_valid && imem_req_ready;
        if (auto_resp && hs) check("req_addr_hs", imem_req_addr, exp_pc);
        @(posedge CLK);
        #1;
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        if (auto_resp && hs) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'hA0 + 32'(n_resp);
            e.pc   = exp_pc;
            e.data = imem_resp_data;
            sb_q.push_back(e);
            exp_pc = exp_pc + 32'd4;
            n_resp++;
        end
        #1;
    endtask

    always @(negedge CLK) begin
        if (reset && inst_valid && inst_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_pending", 32'(sb_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("inst_pc", inst_pc, e.pc);
                check("inst_data", inst_data, e.data);
                if (rate_chk) check("rate", 32'(cyc - last_cons), 32'd2);
                last_cons = cyc;
            end
        end
    end

    initial begin
        reset           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        inst_ready      = 1'b0;
        auto_resp       = 1'b0;
        rate_chk        = 1'b0;
        exp_pc          = 32'h100;

        // Reset: outputs idle, boot vector presented, redirect ignored
        repeat (3) @(posedge CLK);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h44;
        #1;
        check("rst_pc_next", pc_next, 32'h100);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        redirect_valid = 1'b0;
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        #1;
        check("boot_pc_next", pc_next, 32'h100);
        check("boot_req_valid", {31'b0, imem_req_valid}, 32'd0);
        step();
        check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, 32'h100);
        auto_resp = 1'b1;

        // Sequential fetch, then backpressure on the first instruction
        step();
        check("wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
        step();
        check("first_inst_valid", {31'b0, inst_valid}, 32'd1);
        inst_ready = 1'b0;
        #1;
        check("bp_req_valid", {31'b0, imem_req_valid}, 32'd0);
        repeat (3) step();
        check("bp_inst_valid", {31'b0, inst_valid}, 32'd1);
        check("bp_inst_data", inst_data, 32'hA0);
        check("bp_pc_hold", pc_current, 32'h104);
        check("bp_req_valid_hold", {31'b0, imem_req_valid}, 32'd0);
        inst_ready = 1'b1;
        #1;
        check("resume_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("resume_req_addr", imem_req_addr, 32'h104);
        step();
        rate_chk = 1'b1;
        repeat (3) step();
        auto_resp = 1'b0;
        step();
        rate_chk = 1'b0;

        // Redirect in WAIT with no response; late response must be dropped
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        #1;
        check("redir_pc_next", pc_next, 32'h200);
        exp_pc = 32'h200;
        step();
        check("disc_pc", pc_current, 32'h200);
        check("disc_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("disc_req_valid", {31'b0, imem_req_valid}, 32'd0);
        step();
        check("disc_hold_req", {31'b0, imem_req_valid}, 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD;
        step();
        check("late_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("late_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("late_req_addr", imem_req_addr, 32'h200);

        // Flush a full slot by redirect in REQ, then wrap at the top of memory
        auto_resp = 1'b1;
        step();
        step();
        inst_ready     = 1'b0;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        #1;
        check("pre_flush_valid", {31'b0, inst_valid}, 32'd1);
        check("redir_req_pc_next", pc_next, 32'hFFFF_FFFC);
        flushed = sb_q.pop_front();
        exp_pc  = 32'hFFFF_FFFC;
        step();
        check("flush_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("flush_pc", pc_current, 32'hFFFF_FFFC);
        check("flush_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("flush_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        inst_ready     = 1'b1;
        imem_req_ready = 1'b1;
        step();
        check("wrap_pc_next", pc_next, 32'h0);
        auto_resp = 1'b0;
        step();
        check("wrap_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("wrap_req_addr", imem_req_addr, 32'h0);

        // Redirect coincident with response: data dropped, no PC+4
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBEEF;
        redirect_valid  = 1'b1;
        redirect_pc     = 32'h203;
        #1;
        check("coinc_pc_next", pc_next, 32'h200);
        step();
        check("coinc_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("coinc_req_addr", imem_req_addr, 32'h200);

        // Redirect in REQ during a handshake: stale response discarded
        redirect_valid = 1'b1;
        redirect_pc    = 32'h303;
        #1;
        check("reqhs_pc_next", pc_next, 32'h300);
        check("reqhs_req_valid", {31'b0, imem_req_valid}, 32'd1);
        step();
        check("reqhs_disc_req", {31'b0, imem_req_valid}, 32'd0);
        check("reqhs_pc", pc_current, 32'h300);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h77;
        step();
        check("reqhs_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("reqhs_req_valid2", {31'b0, imem_req_valid}, 32'd1);
        check("reqhs_req_addr", imem_req_addr, 32'h300);

        // Asynchronous reset mid-WAIT, between clock edges
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h55;
        #1;
        check("wait_pc_next", pc_next, 32'h304);
        #1;
        reset = 1'b0;
        #1;
        check("arst_pc_next", pc_next, 32'h100);
        check("arst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("arst_inst_data", inst_data, 32'h0);
        check("arst_inst_pc", inst_pc, 32'h0);
        check("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("arst_req_addr", imem_req_addr, 32'h0);
        imem_resp_valid = 1'b0;
        #20;
        check("sb_leftover", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_next_pc.md
Name: fetch_next_pc

Overview:
Fetch controller at the far end of the program counter register. It takes the PC register's output, issues instruction-memory reads at that address and hands fetched instructions downstream. It drives the next value back into the PC register input, which loads on every CLK edge. It owns stall, sequential increment and branch/jump redirect, and is the only driver of the PC input.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address after reset release
INST_STEP, 4, byte increment between sequential instructions

Ports:
CLK  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
pc_current  input  32  PC register output
pc_next  output  32  PC register input; PC loads it every CLK edge
imem_req_valid  output  1  read request valid
imem_req_addr  output  32  read address
imem_req_ready  input  1  memory accepts request this cycle
imem_resp_valid  input  1  read data valid (one pulse per accepted request, no backpressure)
imem_resp_data  input  32  read data
redirect_valid  input  1  branch/jump taken, single-cycle pulse
redirect_pc  input  32  redirect target
inst_valid  output  1  instruction slot full
inst_data  output  32  instruction word
inst_pc  output  32  address of inst_data
inst_ready  input  1  downstream consumes the slot

Behaviour:
- One clock. Reset is asynchronous and active-low: ports CLK and reset. While reset=0:
  - state=BOOT
  - pc_next=RESET_VECTOR
  - imem_req_valid=0, imem_req_addr=0
  - inst_valid=0, inst_data=0, inst_pc=0
- Reset asserted mid-operation aborts everything immediately. Any in-flight response is ignored after release, because BOOT/REQ do not accept responses.
- pc_next is combinational from state and inputs. Default is pc_current (hold/stall).
- Output slot: single registered entry. Slot is "free" when inst_valid=0 or (inst_valid & inst_ready). Consumption clears inst_valid at the next edge unless the slot is refilled that edge.
- At most one outstanding memory request.
- FSM:
  - BOOT: pc_next=RESET_VECTOR for exactly one cycle; then -> REQ.
  - REQ: imem_req_valid = slot free; imem_req_addr=pc_current. If valid & imem_req_ready -> WAIT. Otherwise stay. pc_next=pc_current.
  - WAIT: on imem_resp_valid:
    - inst_data<=imem_resp_data, inst_pc<=pc_current, inst_valid<=1
    - pc_next=pc_current+INST_STEP (mod 2^32, wraps FFFF_FFFC -> 0000_0000)
    - -> REQ
    Otherwise hold.
  - DISCARD: wait for the stale response. On imem_resp_valid, drop the data (slot unchanged) -> REQ. pc_next=pc_current.
- Latency: request issued in the first REQ cycle with slot free. Zero-wait memory (ready=1, response the next cycle) yields one instruction every 2 cycles.
- Redirect (highest priority, any state except BOOT): pc_next={redirect_pc[31:2],2'b00}, inst_valid<=0 (flush, even if inst_ready). Next state:
  - REQ without handshake this cycle -> REQ (the request is withdrawn).
  - REQ with imem_req_valid & imem_req_ready same cycle -> DISCARD.
  - WAIT with imem_resp_valid same cycle -> REQ (response dropped).
  - WAIT without response -> DISCARD.
  - DISCARD -> DISCARD (target updated); if resp arrives same cycle -> REQ.
- Redirect during BOOT is ignored.
- imem_req_valid never asserts in WAIT, DISCARD or BOOT.

Test Plan:
- Reset/boot: hold reset=0 for 3 cycles with RESET_VECTOR=32'h100, then release -> pc_next=0x100 in BOOT; first request addr=0x100; outputs 0 during reset.
- Sequential fetch: ready=1, response 1 cycle later with data 0xA0+n, inst_ready=1 -> inst_pc 0x100, 0x104, 0x108 with data A0, A1, A2, one instruction every 2 cycles.
- Backpressure: inst_ready=0 after the first instruction -> imem_req_valid stays 0; inst_data and pc_current hold at 0x104; raise inst_ready -> fetch of 0x104 resumes.
- Redirect in WAIT, no response: redirect_pc=0x203 -> pc_next=0x200 and inst_valid clears. Late response (0xDEAD) is dropped; the next request addr=0x200.
- Redirect coincident with response: redirect in WAIT same cycle as resp_valid -> data not written; next request is 0x200, not PC+4.
- Wrap and async reset: pc_current=0xFFFF_FFFC, response arrives -> pc_next=0x0. Assert reset mid-WAIT between clock edges -> outputs clear immediately without a clock edge.
